imem_loader: RTL and testbench

//  Boot-time writer for instruction memory. Collects a byte stream over a valid/ready handshake.

---
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a byte stream little-endian into words and writes them from address 0.
// Latency: o_we rises the cycle after the last byte of a word; each word takes at least BYTES+1 cycles.
// Backpressure: o_byte_ready is low outside COLLECT, so the source stalls during WRITE, IDLE and DONE.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  input  logic                  i_abort,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wrdata,
  output logic                  o_core_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(BYTES - 1);
  // DEPTH = 2**ADDR_WIDTH, expressed in the width of i_word_count
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [LANE_W-1:0]       lane_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [DATA_WIDTH-1:0]   word_d;
  logic                    ready_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wrdata_q;
  logic                    hold_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic                    count_legal;
  logic                    last_word;
  logic                    byte_fire;

  // Merge the incoming byte into its lane and evaluate start legality / last-word condition
  always_comb begin
    word_d = word_q;
    word_d[{lane_q, 3'b000} +: 8] = i_byte;
    count_legal = (i_word_count != '0) && (i_word_count <= DEPTH);
    last_word   = ({1'b0, idx_q} == (count_q - 1'b1));
    byte_fire   = i_byte_valid & ready_q;
  end

  // Load sequencer with every output registered alongside the state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      word_q   <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
      hold_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            if (!count_legal) begin
              // illegal count: flag it and park in IDLE; hold/done keep their levels
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              count_q <= i_word_count;
              idx_q   <= '0;
              lane_q  <= '0;
              error_q <= 1'b0;
              done_q  <= 1'b0;
              hold_q  <= 1'b1;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (i_abort) begin
            // abort wins over a same-cycle byte; partial word is dropped
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (byte_fire) begin
            word_q <= word_d;
            if (lane_q == LAST_LANE) begin
              we_q     <= 1'b1;
              addr_q   <= idx_q;
              wrdata_q <= word_d;
              ready_q  <= 1'b0;
              state_q  <= S_WRITE;
            end else begin
              lane_q <= lane_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          // the write being presented this cycle completes regardless of abort
          we_q <= 1'b0;
          if (i_abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (last_word) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            lane_q  <= '0;
            ready_q <= 1'b1;
            state_q <= S_COLLECT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_byte_ready = ready_q;
  assign o_we         = we_q;
  assign o_addr       = addr_q;
  assign o_wrdata     = wrdata_q;
  assign o_core_hold  = hold_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte streams and loads checked every cycle against a behavioural model.
// The model tracks load progress as a byte queue plus word index; shadow memory captures DUT writes.
// Literal checks pin the known boot image, error handling, abort and full-depth load.
module tb_imem_loader;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          abort = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wrdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_word_count(word_count),
    .i_abort(abort), .i_byte_valid(byte_valid), .i_byte(byte_in),
    .o_byte_ready(byte_ready), .o_we(we), .o_addr(addr), .o_wrdata(wrdata),
    .o_core_hold(core_hold), .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            started = 0;
  bit            m_busy = 0;
  logic          m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_rdy = 0;
  logic          m_hold = 1;
  logic          m_done = 0;
  logic          m_err = 0;
  int            m_cnt = 0;
  int            m_idx = 0;
  logic [7:0]    m_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_we = 0; m_addr = '0; m_data = '0; m_rdy = 0;
      m_hold = 1; m_done = 0; m_err = 0; m_q.delete();
    end else if (m_busy && m_we) begin
      m_we = 0;
      if (abort) m_busy = 0;
      else if (m_idx == m_cnt - 1) begin
        m_busy = 0; m_done = 1; m_hold = 0;
      end else begin
        m_idx++; m_rdy = 1;
      end
    end else if (m_busy) begin
      if (abort) begin
        m_busy = 0; m_rdy = 0; m_q.delete();
      end else if (byte_valid) begin
        m_q.push_back(byte_in);
        if (m_q.size() == DW / 8) begin
          m_data = '0;
          for (int i = 0; i < DW / 8; i++) m_data = m_data | (DW'(m_q[i]) << (8 * i));
          m_we = 1; m_addr = AW'(m_idx); m_rdy = 0; m_q.delete();
        end
      end
    end else if (start) begin
      if (word_count == 0 || int'(word_count) > (1 << AW)) m_err = 1;
      else begin
        m_cnt = int'(word_count); m_idx = 0; m_busy = 1; m_rdy = 1;
        m_done = 0; m_err = 0; m_hold = 1; m_q.delete();
      end
    end
    started = 1;
  end

  // ---------------- per-cycle compare + write capture ----------------
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int wr_count = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("byte_ready", 64'(byte_ready), 64'(m_rdy));
      chk("we",         64'(we),         64'(m_we));
      chk("addr",       64'(addr),       64'(m_addr));
      chk("wrdata",     64'(wrdata),     64'(m_data));
      chk("core_hold",  64'(core_hold),  64'(m_hold));
      chk("busy",       64'(busy),       64'(m_busy));
      chk("done",       64'(done),       64'(m_done));
      chk("error",      64'(error),      64'(m_err));
      if (we === 1'b1) begin
        shadow[addr] = wrdata;
        wr_count++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] sbuf [0:4095];

  task automatic do_start(input int c);
    @(negedge clk);
    start = 1'b1; word_count = (AW+1)'(c);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_stream(input int base, input int n, input bit rnd);
    int i = 0;
    int budget = 20 * n + 50;
    while (i < n && budget > 0) begin
      @(negedge clk);
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in = byte_valid ? sbuf[base + i] : 8'($urandom);
      if (byte_valid && byte_ready) i++;
      budget--;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (i < n) chk("stream_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input int budget);
    int b = budget;
    while (done !== 1'b1 && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (done !== 1'b1) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1; byte_valid = 1'b1; byte_in = 8'hEE;
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic load_boot_image();
    sbuf[0] = 8'h13; sbuf[1] = 8'h00; sbuf[2] = 8'h00; sbuf[3] = 8'h00;
    sbuf[4] = 8'h93; sbuf[5] = 8'h00; sbuf[6] = 8'h10; sbuf[7] = 8'h00;
  endtask

  int w0;

  initial begin
    // 1. reset held three cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_hold", 64'(core_hold), 64'd1);
      chk("rst_we",   64'(we),        64'd0);
    end
    rst = 1'b0;

    // 2. two-word boot image, valid held high
    load_boot_image();
    w0 = wr_count;
    do_start(2);
    send_stream(0, 8, 1'b0);
    wait_done(40);
    chk("img_w0", 64'(shadow[0]), 64'h00000013);
    chk("img_w1", 64'(shadow[1]), 64'h00100093);
    chk("img_writes", 64'(wr_count - w0), 64'd2);
    chk("img_hold", 64'(core_hold), 64'd0);

    // 3. same image, random valid
    shadow[0] = '0; shadow[1] = '0;
    w0 = wr_count;
    do_start(2);
    send_stream(0, 8, 1'b1);
    wait_done(40);
    chk("rnd_w0", 64'(shadow[0]), 64'h00000013);
    chk("rnd_w1", 64'(shadow[1]), 64'h00100093);
    chk("rnd_writes", 64'(wr_count - w0), 64'd2);

    // 4. illegal counts: 0 and DEPTH+1
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    w0 = wr_count;
    do_start(0);
    @(negedge clk);
    chk("err_zero", 64'(error), 64'd1);
    do_start(1025);
    @(negedge clk);
    chk("err_big", 64'(error), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_nowrite", 64'(wr_count - w0), 64'd0);
    sbuf[0] = 8'hA1; sbuf[1] = 8'hB2; sbuf[2] = 8'hC3; sbuf[3] = 8'hD4;
    do_start(1);
    chk("err_clear", 64'(error), 64'd0);
    send_stream(0, 4, 1'b0);
    wait_done(20);
    chk("err_w0", 64'(shadow[0]), 64'hD4C3B2A1);

    // 5. abort after two bytes of word 1
    for (int i = 0; i < 12; i++) sbuf[i] = 8'(8'h40 + i);
    w0 = wr_count;
    do_start(3);
    send_stream(0, 6, 1'b0);
    do_abort();
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hold", 64'(core_hold), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_writes", 64'(wr_count - w0), 64'd1);
    load_boot_image();
    do_start(2);
    send_stream(0, 8, 1'b1);
    wait_done(40);
    chk("restart_w0", 64'(shadow[0]), 64'h00000013);
    chk("restart_w1", 64'(shadow[1]), 64'h00100093);

    // illegal start from DONE keeps the done level
    do_start(0);
    @(negedge clk);
    chk("err_from_done", 64'(error), 64'd1);

    // random loads with occasional aborts
    for (int r = 0; r < 8; r++) begin
      int cnt = $urandom_range(1, 6);
      int nb = cnt * 4;
      for (int i = 0; i < nb; i++) sbuf[i] = 8'($urandom);
      do_start(cnt);
      if ($urandom_range(0, 3) == 0) begin
        send_stream(0, $urandom_range(0, nb - 1), 1'b1);
        do_abort();
      end else begin
        send_stream(0, nb, 1'b1);
        wait_done(40);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // 6. full-depth load with a start pulse ignored mid-load
    for (int i = 0; i < 4096; i++) sbuf[i] = 8'(i);
    w0 = wr_count;
    do_start(1024);
    send_stream(0, 2048, 1'b0);
    do_start(5);
    chk("mid_start_busy", 64'(busy), 64'd1);
    send_stream(2048, 2048, 1'b0);
    wait_done(40);
    chk("full_writes", 64'(wr_count - w0), 64'd1024);
    chk("full_first", 64'(shadow[0]), 64'h03020100);
    chk("full_last", 64'(shadow[1023]), 64'hFFFEFDFC);
    chk("full_addr", 64'(addr), 64'd1023);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
